uart_feedback_frame_rx: RTL and testbench
=========================================

Name: uart_feedback_frame_rx

Overview:
- Parametrised successor to the single-byte UART feedback decoder.
- Assembles an N_SIG-bit feedback vector from one or more UART bytes and commits it atomically.
- Adds three things the single-byte decoder lacks: an inter-byte timeout, a staleness auto-clear, and error/commit strobes.
- Sits between the UART byte receiver and the LED/status logic, in the uart_clk domain.

Parameters:
- N_SIG, 4, number of feedback signals; legal range 1..48.
- TIMEOUT_CYC, 1000, maximum idle uart_clk cycles between bytes of one frame; must be >= 1.
- STALE_CYC, 0, uart_clk cycles after a commit before outputs auto-clear; 0 disables the feature.
- Derived: BYTES = ceil(N_SIG/6), number of bytes per frame.

Ports:
- uart_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- script_mode  in  1  script mode active; forces outputs clear.
- data_valid  in  1  data_receive is valid this cycle (single-cycle strobe per byte).
- data_receive  in  8  received byte: [1:0] type, [7:2] payload chunk.
- sig  out  N_SIG  committed feedback vector.
- feedback_leds  out  N_SIG  LED mirror of sig.
- led_mode  out  1  high while a valid feedback vector is held.
- frame_valid  out  1  one-cycle pulse on commit.
- frame_err  out  1  one-cycle pulse on abort.
- stale  out  1  sticky; set when the staleness timer clears the outputs.

Behaviour:
- Reset (synchronous, rst high at the edge):
  - state = IDLE; byte index = 0.
  - sig, feedback_leds, led_mode, frame_valid, frame_err, stale = 0.
  - Both timers cleared.
- Type codes: FEEDBACK = 2'b01 (first byte of a frame), CONT = 2'b11 (continuation byte). 2'b00 and 2'b10 are script bytes.
- Chunk mapping: byte k carries sig[6k+5 : 6k]. Payload bits above N_SIG-1 in the last byte are ignored.
- IDLE state:
  - FEEDBACK byte with BYTES = 1: commit immediately.
  - FEEDBACK byte with BYTES > 1: store chunk 0, index = 1, go to COLLECT.
  - CONT byte: drop it and pulse frame_err.
  - Script byte: clear sig, feedback_leds and led_mode (legacy behaviour); no error.
- COLLECT state:
  - CONT byte: store the chunk at the current index and increment the index. On index = BYTES-1, commit and go to IDLE.
  - FEEDBACK byte: pulse frame_err, discard the partial frame, restart with this byte as chunk 0.
  - Script byte: pulse frame_err, clear the outputs as in IDLE, go to IDLE.
- Commit (registered at the edge that samples the last byte):
  - sig and feedback_leds take the assembled vector; led_mode = 1; stale = 0.
  - frame_valid is high for the following cycle.
  - Staleness timer restarts.
  - A partial frame never alters sig.
- Timeout:
  - The timeout timer counts cycles in COLLECT with no data_valid and resets on every accepted byte.
  - Reaching TIMEOUT_CYC returns to IDLE with a frame_err pulse; sig is unchanged.
  - If data_valid coincides with the terminal count, the byte wins and there is no timeout.
- Staleness (STALE_CYC > 0 only):
  - STALE_CYC cycles after the last commit with no new commit: sig, feedback_leds and led_mode clear; stale = 1.
  - A commit on the terminal-count cycle wins.
- script_mode high (every cycle, data_valid not required):
  - Outputs clear, state goes to IDLE, partial frame discarded silently (no frame_err).
  - Bytes are ignored and timers are held clear.
- Priority: rst > script_mode > data_valid byte > timeout/staleness.
- frame_valid and frame_err are never high in the same cycle.

Decomposition:
- Package uart_fb_pkg holds:
  - type codes FEEDBACK, CONT, SCRIPT0, SCRIPT1;
  - CHUNK_W = 6;
  - state enum {IDLE, COLLECT}.
- Sub-module fb_cycle_timer: up-counter with parameter LIMIT and inputs clr/en; outputs a terminal flag. Instantiated twice, for timeout and staleness.

Test Plan:
1. N_SIG=4, one byte 0x35 -> sig = 4'hD, led_mode = 1, frame_valid pulses once, frame_err stays 0.
2. N_SIG=10, bytes 0xAD then 0x27 -> sig = 10'h26B only after the second byte; sig is unchanged between the two bytes; frame_valid pulses once.
3. N_SIG=10, TIMEOUT_CYC=8, byte 0xAD then an 8-cycle gap -> frame_err pulse, state returns to IDLE. A following 0x27 is dropped with a frame_err pulse; sig keeps its prior value.
4. N_SIG=10, sequence 0xAD, 0xAD, 0x27 -> frame_err pulse on the second byte, then commit of 10'h26B.
5. STALE_CYC=16, commit 0x35 with no further bytes -> at 16 cycles sig = 0, led_mode = 0, stale = 1. A new commit clears stale.
6. script_mode asserted mid-frame, or rst asserted mid-frame -> next edge: all outputs 0, state IDLE, no frame_err. After release, a fresh 2-byte frame commits normally.

Source files
------------

// File: rtl/uart_feedback_frame_rx_pkg.sv
// uart_fb_pkg: shared types and constants for the UART feedback frame receiver.
// Holds the byte type codes carried in data_receive[1:0], the payload chunk
// width, the receiver state encoding and a helper that sizes a frame.
package uart_fb_pkg;

  localparam int CHUNK_W = 6;

  typedef enum logic [1:0] {
    SCRIPT0  = 2'b00,
    FEEDBACK = 2'b01,
    SCRIPT1  = 2'b10,
    CONT     = 2'b11
  } byte_type_e;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Number of bytes needed to carry n_sig feedback bits, CHUNK_W bits per byte.
  function automatic int frame_bytes(input int n_sig);
    return (n_sig + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/uart_feedback_frame_rx_if.sv
// uart_feedback_frame_rx_if: byte stream from the UART byte receiver.
//   data_valid    single-cycle strobe, data_receive holds a byte this cycle
//   data_receive  [1:0] byte type, [7:2] payload chunk
// master drives the byte stream, slave consumes it.
interface uart_feedback_frame_rx_if;

  logic       data_valid;
  logic [7:0] data_receive;

  modport master (
    output data_valid,
    output data_receive
  );

  modport slave (
    input data_valid,
    input data_receive
  );

endinterface

// File: rtl/uart_feedback_frame_rx_timer.sv
// fb_cycle_timer: up-counter that flags the LIMIT-th enabled cycle.
//   uart_clk  clock
//   rst       synchronous active-high reset
//   clr       clears the count (wins over en)
//   en        count this cycle
//   tc        high on the enabled cycle that completes LIMIT counts
// tc depends only on en and the count, never on clr, so callers may derive
// clr from logic that itself looks at tc without forming a loop.
module fb_cycle_timer #(
  parameter int LIMIT = 1
) (
  input  logic uart_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = en && (cnt_q == LAST);

  always_ff @(posedge uart_clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_feedback_frame_rx.sv
// uart_feedback_frame_rx: assembles an N_SIG-bit feedback vector from one or
// more UART bytes and commits it atomically, with inter-byte timeout,
// staleness auto-clear and commit/abort strobes.
//   uart_clk       sole clock
//   rst            synchronous active-high reset
//   script_mode    forces outputs clear and discards any partial frame
//   rx             byte stream (data_valid, data_receive)
//   sig            committed feedback vector
//   feedback_leds  LED mirror of sig
//   led_mode       high while a valid feedback vector is held
//   frame_valid    one-cycle pulse on commit
//   frame_err      one-cycle pulse on abort
//   stale          sticky, set when the staleness timer clears the outputs
//
// state   | meaning
// IDLE    | no partial frame held; waiting for a FEEDBACK byte
// COLLECT | chunks 0..idx-1 held; waiting for CONT bytes up to BYTES-1
module uart_feedback_frame_rx
  import uart_fb_pkg::*;
#(
  parameter int N_SIG       = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int STALE_CYC   = 0
) (
  input  logic                      uart_clk,
  input  logic                      rst,
  input  logic                      script_mode,
  uart_feedback_frame_rx_if.slave   rx,
  output logic [N_SIG-1:0]          sig,
  output logic [N_SIG-1:0]          feedback_leds,
  output logic                      led_mode,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      stale
);

  localparam int BYTES       = frame_bytes(N_SIG);
  localparam int BUF_W       = BYTES * CHUNK_W;
  localparam int IDX_W       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int STALE_LIMIT = (STALE_CYC > 0) ? STALE_CYC : 1;
  localparam bit STALE_ON    = (STALE_CYC > 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BUF_W-1:0]   frame_q, frame_d;
  logic [BUF_W-1:0]   assembled;
  logic [N_SIG-1:0]   sig_d;
  logic               led_d, fv_d, fe_d, stale_d;
  logic               commit;
  byte_type_e         byte_type;
  logic [CHUNK_W-1:0] payload;

  logic tmo_clr, tmo_en, tmo_tc;
  logic stl_clr, stl_en, stl_tc;

  // Timeout counts only idle cycles inside a frame; any byte restarts it.
  assign tmo_en  = (state_q == COLLECT) && !rx.data_valid && !script_mode;
  assign tmo_clr = script_mode || rx.data_valid || (state_q != COLLECT);

  // Staleness runs while a vector is held; a commit restarts it.
  assign stl_en  = STALE_ON && led_mode;
  assign stl_clr = script_mode || commit || !led_mode;

  fb_cycle_timer #(.LIMIT(TIMEOUT_CYC)) u_tmo_timer (
    .uart_clk (uart_clk),
    .rst      (rst),
    .clr      (tmo_clr),
    .en       (tmo_en),
    .tc       (tmo_tc)
  );

  fb_cycle_timer #(.LIMIT(STALE_LIMIT)) u_stale_timer (
    .uart_clk (uart_clk),
    .rst      (rst),
    .clr      (stl_clr),
    .en       (stl_en),
    .tc       (stl_tc)
  );

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      frame_q     <= '0;
      sig         <= '0;
      led_mode    <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      sig         <= sig_d;
      led_mode    <= led_d;
      frame_valid <= fv_d;
      frame_err   <= fe_d;
      stale       <= stale_d;
    end
  end

  assign feedback_leds = sig;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    assembled = frame_q;
    sig_d     = sig;
    led_d     = led_mode;
    stale_d   = stale;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    commit    = 1'b0;
    byte_type = byte_type_e'(rx.data_receive[1:0]);
    payload   = rx.data_receive[7:2];

    if (script_mode) begin
      // Silent abort: no frame_err even when a frame was in progress.
      state_d = IDLE;
      idx_d   = '0;
      sig_d   = '0;
      led_d   = 1'b0;
      stale_d = 1'b0;
    end else begin
      if (rx.data_valid) begin
        unique case (state_q)
          IDLE: begin
            case (byte_type)
              FEEDBACK: begin
                assembled                = '0;
                assembled[CHUNK_W-1:0]   = payload;
                if (BYTES == 1) begin
                  commit = 1'b1;
                end else begin
                  frame_d = assembled;
                  idx_d   = IDX_W'(1);
                  state_d = COLLECT;
                end
              end
              CONT: fe_d = 1'b1;
              default: begin
                sig_d = '0;
                led_d = 1'b0;
              end
            endcase
          end
          COLLECT: begin
            case (byte_type)
              CONT: begin
                assembled[idx_q*CHUNK_W +: CHUNK_W] = payload;
                frame_d = assembled;
                if (idx_q == IDX_W'(BYTES - 1)) begin
                  commit  = 1'b1;
                  state_d = IDLE;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end
              FEEDBACK: begin
                // Abandon the partial frame and start over from this byte.
                fe_d                   = 1'b1;
                frame_d                = '0;
                frame_d[CHUNK_W-1:0]   = payload;
                idx_d                  = IDX_W'(1);
              end
              default: begin
                fe_d    = 1'b1;
                sig_d   = '0;
                led_d   = 1'b0;
                state_d = IDLE;
                idx_d   = '0;
              end
            endcase
          end
        endcase
      end else if (tmo_tc) begin
        state_d = IDLE;
        idx_d   = '0;
        fe_d    = 1'b1;
      end

      // A commit landing on the staleness terminal cycle keeps the new vector.
      if (commit) begin
        sig_d   = assembled[N_SIG-1:0];
        led_d   = 1'b1;
        stale_d = 1'b0;
        fv_d    = 1'b1;
      end else if (stl_tc) begin
        sig_d   = '0;
        led_d   = 1'b0;
        stale_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_feedback_frame_rx.sv
module tb_uart_feedback_frame_rx;

  localparam int NI   = 3;
  localparam int NS_A = 4;
  localparam int TO_A = 1000;
  localparam int ST_A = 16;
  localparam int NS_B = 10;
  localparam int TO_B = 8;
  localparam int ST_B = 0;
  localparam int NS_C = 13;
  localparam int TO_C = 5;
  localparam int ST_C = 40;

  logic uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  logic rst;
  logic script_mode;
  uart_feedback_frame_rx_if bus ();

  logic [NS_A-1:0] sig_a, leds_a;
  logic [NS_B-1:0] sig_b, leds_b;
  logic [NS_C-1:0] sig_c, leds_c;
  logic led_a, fv_a, fe_a, st_a;
  logic led_b, fv_b, fe_b, st_b;
  logic led_c, fv_c, fe_c, st_c;

  uart_feedback_frame_rx #(.N_SIG(NS_A), .TIMEOUT_CYC(TO_A), .STALE_CYC(ST_A)) dut_a (
    .uart_clk (uart_clk), .rst (rst), .script_mode (script_mode), .rx (bus),
    .sig (sig_a), .feedback_leds (leds_a), .led_mode (led_a),
    .frame_valid (fv_a), .frame_err (fe_a), .stale (st_a)
  );

  uart_feedback_frame_rx #(.N_SIG(NS_B), .TIMEOUT_CYC(TO_B), .STALE_CYC(ST_B)) dut_b (
    .uart_clk (uart_clk), .rst (rst), .script_mode (script_mode), .rx (bus),
    .sig (sig_b), .feedback_leds (leds_b), .led_mode (led_b),
    .frame_valid (fv_b), .frame_err (fe_b), .stale (st_b)
  );

  uart_feedback_frame_rx #(.N_SIG(NS_C), .TIMEOUT_CYC(TO_C), .STALE_CYC(ST_C)) dut_c (
    .uart_clk (uart_clk), .rst (rst), .script_mode (script_mode), .rx (bus),
    .sig (sig_c), .feedback_leds (leds_c), .led_mode (led_c),
    .frame_valid (fv_c), .frame_err (fe_c), .stale (st_c)
  );

  logic [99:0] obs [NI];
  assign obs[0] = {st_a, fe_a, fv_a, led_a, 48'(leds_a), 48'(sig_a)};
  assign obs[1] = {st_b, fe_b, fv_b, led_b, 48'(leds_b), 48'(sig_b)};
  assign obs[2] = {st_c, fe_c, fv_c, led_c, 48'(leds_c), 48'(sig_c)};

  // Reference model: a frame is a list of received chunks; it commits once
  // enough chunks have arrived. Idle time inside a frame and time since the
  // last commit are tracked as plain cycle counts.
  int        m_nsig  [NI];
  int        m_bytes [NI];
  int        m_tmo   [NI];
  int        m_stl   [NI];
  bit        m_in    [NI];
  int        m_got   [NI];
  int        m_gap   [NI];
  int        m_age   [NI];
  bit [47:0] m_part  [NI];
  bit [47:0] m_sig   [NI];
  bit        m_led   [NI];
  bit        m_stale [NI];
  bit        m_fv    [NI];
  bit        m_fe    [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic model_step();
    logic [1:0] t;
    logic [5:0] p;
    bit         commit;
    bit         led_prev;
    bit [63:0]  mk;
    t = bus.data_receive[1:0];
    p = bus.data_receive[7:2];
    for (int k = 0; k < NI; k++) begin
      m_fv[k]  = 1'b0;
      m_fe[k]  = 1'b0;
      commit   = 1'b0;
      led_prev = m_led[k];
      if (rst) begin
        m_in[k] = 0; m_got[k] = 0; m_gap[k] = 0; m_age[k] = 0;
        m_part[k] = '0; m_sig[k] = '0; m_led[k] = 0; m_stale[k] = 0;
      end else if (script_mode) begin
        m_in[k] = 0; m_got[k] = 0; m_gap[k] = 0; m_age[k] = 0;
        m_sig[k] = '0; m_led[k] = 0; m_stale[k] = 0;
      end else begin
        if (bus.data_valid) begin
          if (t == 2'b01) begin
            if (m_in[k]) m_fe[k] = 1'b1;
            m_part[k] = 48'(p);
            m_got[k]  = 1;
            m_gap[k]  = 0;
            if (m_bytes[k] == 1) begin
              commit  = 1'b1;
              m_in[k] = 1'b0;
            end else begin
              m_in[k] = 1'b1;
            end
          end else if (t == 2'b11) begin
            if (!m_in[k]) begin
              m_fe[k] = 1'b1;
            end else begin
              m_part[k] = m_part[k] | (48'(p) << (6 * m_got[k]));
              m_got[k]++;
              m_gap[k] = 0;
              if (m_got[k] == m_bytes[k]) begin
                commit  = 1'b1;
                m_in[k] = 1'b0;
              end
            end
          end else begin
            if (m_in[k]) m_fe[k] = 1'b1;
            m_in[k]  = 1'b0;
            m_sig[k] = '0;
            m_led[k] = 1'b0;
          end
        end else if (m_in[k]) begin
          m_gap[k]++;
          if (m_gap[k] == m_tmo[k]) begin
            m_fe[k] = 1'b1;
            m_in[k] = 1'b0;
          end
        end
        if (commit) begin
          mk         = (64'd1 << m_nsig[k]) - 64'd1;
          m_sig[k]   = m_part[k] & mk[47:0];
          m_led[k]   = 1'b1;
          m_stale[k] = 1'b0;
          m_fv[k]    = 1'b1;
          m_age[k]   = 0;
        end else if (m_stl[k] > 0 && led_prev) begin
          m_age[k]++;
          if (m_age[k] == m_stl[k]) begin
            m_sig[k]   = '0;
            m_led[k]   = 1'b0;
            m_stale[k] = 1'b1;
            m_age[k]   = 0;
          end
        end else begin
          m_age[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [99:0] exp_vec(input int k);
    return {m_stale[k], m_fe[k], m_fv[k], m_led[k], m_sig[k], m_sig[k]};
  endfunction

  task automatic tick();
    @(posedge uart_clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic step(input bit dv, input logic [7:0] b);
    bus.data_valid   = dv;
    bus.data_receive = b;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    script_mode = 1'b0;
    step(1'b0, 8'h00);
    step(1'b1, 8'h35);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (obs[k] !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL reset inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
      end
    end
    n_tests++;
    if ({sig_b, led_b, fv_b, fe_b, st_b} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got %h expected 0", {sig_b, led_b, fv_b, fe_b, st_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    for (int i = 0; i < 3; i++) begin
      step(i == 0, (i == 0) ? 8'h35 : 8'h00);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL single_byte inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      n_tests++;
      if (i == 0 && {sig_a, led_a, fv_a, fe_a} !== {4'hD, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_byte_commit: got %h expected %h", {sig_a, led_a, fv_a, fe_a}, {4'hD, 3'b110});
      end else if (i > 0 && (fv_a !== 1'b0 || fe_a !== 1'b0 || sig_a !== 4'hD)) begin
        n_fail++;
        $display("FAIL single_byte_hold: got sig %h fv %b fe %b expected D 0 0", sig_a, fv_a, fe_a);
      end
    end
  endtask

  task automatic test_two_byte();
    logic [8:0] seq [4];
    seq = '{9'h1AD, 9'h000, 9'h000, 9'h127};
    for (int i = 0; i < 4; i++) begin
      step(seq[i][8], seq[i][7:0]);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL two_byte inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      n_tests++;
      if (i < 3 && (sig_b !== 10'h000 || fv_b !== 1'b0)) begin
        n_fail++;
        $display("FAIL two_byte_partial: got sig %h fv %b expected 000 0", sig_b, fv_b);
      end else if (i == 3 && (sig_b !== 10'h26B || fv_b !== 1'b1 || led_b !== 1'b1)) begin
        n_fail++;
        $display("FAIL two_byte_commit: got sig %h fv %b led %b expected 26b 1 1", sig_b, fv_b, led_b);
      end
    end
  endtask

  task automatic test_timeout();
    logic [8:0] seq [$];
    seq.push_back(9'h1AD);
    for (int i = 0; i < TO_B; i++) seq.push_back(9'h000);
    seq.push_back(9'h127);
    seq.push_back(9'h1AD);
    for (int i = 0; i < TO_B - 1; i++) seq.push_back(9'h000);
    seq.push_back(9'h127);
    for (int i = 0; i < seq.size(); i++) begin
      step(seq[i][8], seq[i][7:0]);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL timeout inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (i == TO_B - 1 || i == TO_B || i == TO_B + 1) begin
        n_tests++;
        if (fe_b !== (i != TO_B - 1) || sig_b !== 10'h26B || fv_b !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_abort step%0d: got fe %b sig %h fv %b expected fe %b sig 26b fv 0",
                   i, fe_b, sig_b, fv_b, i != TO_B - 1);
        end
      end
      if (i == seq.size() - 1) begin
        n_tests++;
        if (fv_b !== 1'b1 || fe_b !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_boundary: got fv %b fe %b expected 1 0", fv_b, fe_b);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [8:0] seq [5];
    seq = '{9'h101, 9'h103, 9'h1AD, 9'h1AD, 9'h127};
    for (int i = 0; i < 5; i++) begin
      step(seq[i][8], seq[i][7:0]);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL restart inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      n_tests++;
      if (i == 1 && (sig_b !== 10'h000 || fv_b !== 1'b1)) begin
        n_fail++;
        $display("FAIL restart_zero: got sig %h fv %b expected 000 1", sig_b, fv_b);
      end else if (i == 3 && (fe_b !== 1'b1 || fv_b !== 1'b0 || sig_b !== 10'h000)) begin
        n_fail++;
        $display("FAIL restart_err: got fe %b fv %b sig %h expected 1 0 000", fe_b, fv_b, sig_b);
      end else if (i == 4 && (sig_b !== 10'h26B || fv_b !== 1'b1 || fe_b !== 1'b0)) begin
        n_fail++;
        $display("FAIL restart_commit: got sig %h fv %b fe %b expected 26b 1 0", sig_b, fv_b, fe_b);
      end
    end
  endtask

  task automatic test_stale();
    logic [8:0] seq [$];
    seq.push_back(9'h135);
    for (int i = 0; i < ST_A; i++) seq.push_back(9'h000);
    seq.push_back(9'h135);
    for (int i = 0; i < ST_A - 1; i++) seq.push_back(9'h000);
    seq.push_back(9'h135);
    for (int i = 0; i < seq.size(); i++) begin
      step(seq[i][8], seq[i][7:0]);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL stale inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (i == ST_A - 1) begin
        n_tests++;
        if ({sig_a, led_a, st_a} !== {4'hD, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL stale_early: got %h expected %h", {sig_a, led_a, st_a}, {4'hD, 2'b10});
        end
      end else if (i == ST_A) begin
        n_tests++;
        if ({sig_a, led_a, st_a, leds_a} !== {4'h0, 1'b0, 1'b1, 4'h0}) begin
          n_fail++;
          $display("FAIL stale_clear: got %h expected %h", {sig_a, led_a, st_a, leds_a}, 10'h010);
        end
      end else if (i == ST_A + 1 || i == seq.size() - 1) begin
        n_tests++;
        if ({sig_a, led_a, st_a, fv_a} !== {4'hD, 1'b1, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL stale_recommit step%0d: got %h expected %h", i, {sig_a, led_a, st_a, fv_a}, {4'hD, 3'b101});
        end
      end
    end
  endtask

  task automatic test_script_rst();
    logic [10:0] seq [9];
    seq = '{11'h1AD, 11'h200, 11'h327, 11'h1AD, 11'h127, 11'h1AD, 11'h400, 11'h1AD, 11'h127};
    for (int i = 0; i < 9; i++) begin
      rst         = seq[i][10];
      script_mode = seq[i][9];
      step(seq[i][8], seq[i][7:0]);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL script_rst inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      if (i == 1 || i == 2 || i == 6) begin
        n_tests++;
        if ({sig_b, led_b, fe_b, fv_b, st_b} !== 14'h0) begin
          n_fail++;
          $display("FAIL script_rst_clear step%0d: got %h expected 0", i, {sig_b, led_b, fe_b, fv_b, st_b});
        end
      end else if (i == 4 || i == 8) begin
        n_tests++;
        if (sig_b !== 10'h26B || fv_b !== 1'b1) begin
          n_fail++;
          $display("FAIL script_rst_fresh step%0d: got sig %h fv %b expected 26b 1", i, sig_b, fv_b);
        end
      end
    end
    rst = 1'b0;
    script_mode = 1'b0;
  endtask

  task automatic test_random();
    bit         dense;
    int         r;
    logic [7:0] b;
    for (int c = 0; c < 800; c++) begin
      dense       = ((c / 40) % 2) == 0;
      rst         = ($urandom_range(0, 299) == 0);
      script_mode = ($urandom_range(0, 79) == 0);
      r           = $urandom_range(0, 99);
      b[7:2]      = 6'($urandom);
      b[1:0]      = (r < 45) ? 2'b01 : (r < 90) ? 2'b11 : ((r % 2) == 0 ? 2'b00 : 2'b10);
      step($urandom_range(0, 99) < (dense ? 70 : 8), b);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (obs[k] !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, cyc, obs[k], exp_vec(k));
        end
      end
      n_tests++;
      if (fv_a && fe_a || fv_b && fe_b || fv_c && fe_c) begin
        n_fail++;
        $display("FAIL random_exclusive cyc%0d: got fv/fe %b%b %b%b %b%b expected not both",
                 cyc, fv_a, fe_a, fv_b, fe_b, fv_c, fe_c);
      end
    end
    rst = 1'b0;
    script_mode = 1'b0;
  endtask

  initial begin
    m_nsig  = '{NS_A, NS_B, NS_C};
    m_bytes = '{(NS_A + 5) / 6, (NS_B + 5) / 6, (NS_C + 5) / 6};
    m_tmo   = '{TO_A, TO_B, TO_C};
    m_stl   = '{ST_A, ST_B, ST_C};
    rst = 1'b1;
    script_mode = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_receive = 8'h00;
    test_reset();
    test_single_byte();
    test_two_byte();
    test_timeout();
    test_restart();
    test_stale();
    test_script_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
